noc_router: RTL and testbench

Crossbar router at the NoC end of the CPU valid/ready links: accepts 64-bit words from `CPU_NB` CPU ports on the cpu->noc channel and delivers each one, unmodified, on the noc->cpu channel of the destination CPU. The destination is encoded in the word itself. Each destination has its own output FIFO and its own round-robin arbiter. It instantiates once in the top-level testbench between the `cpu` instances.

---
 rtl/noc_router.sv | 112 +++++++++++
 tb/tb_noc_router.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router.sv
// Crossbar router: CPU_NB sources feed CPU_NB destination FIFOs, each guarded by its own
// round-robin arbiter. The destination index sits in the low bits of byte 7 of each word.
module noc_router #(
   parameter int CPU_NB     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CPU_NB-1:0]    data_cpu_to_noc_vld,
   output logic [CPU_NB-1:0]    data_cpu_to_noc_rdy,
   input  logic [CPU_NB*64-1:0] data_cpu_to_noc,
   output logic [CPU_NB-1:0]    data_noc_to_cpu_vld,
   input  logic [CPU_NB-1:0]    data_noc_to_cpu_rdy,
   output logic [CPU_NB*64-1:0] data_noc_to_cpu,
   output logic [31:0]          routed_count
);
   localparam int DW = $clog2(CPU_NB);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   logic [DW-1:0]     w_dest     [CPU_NB];
   logic [DW-1:0]     w_grantSrc [CPU_NB];
   logic [DW-1:0]     w_idx;
   logic [CPU_NB-1:0] w_full;
   logic [CPU_NB-1:0] w_push;
   logic [CPU_NB-1:0] w_pop;
   logic [CPU_NB-1:0] w_grantRdy;
   logic [31:0]       w_grantCount;

   logic [DW-1:0]     r_rr    [CPU_NB];
   logic [PW:0]       r_count [CPU_NB];
   logic [PW-1:0]     r_wrPtr [CPU_NB];
   logic [PW-1:0]     r_rdPtr [CPU_NB];
   logic [63:0]       r_mem   [CPU_NB][FIFO_DEPTH];
   logic [31:0]       r_routedCount;

   always_comb begin
      for (int i = 0; i < CPU_NB; i++) begin
         w_dest[i] = data_cpu_to_noc[i*64+56 +: DW];
         w_full[i] = (r_count[i] == FULL_CNT);
         w_pop[i]  = (r_count[i] != '0) && data_noc_to_cpu_rdy[i];
      end
   end

   // Scanning from the farthest candidate back toward rr leaves the nearest requester as winner.
   always_comb begin
      w_push     = '0;
      w_grantRdy = '0;
      w_idx      = '0;
      for (int j = 0; j < CPU_NB; j++) begin
         w_grantSrc[j] = '0;
         for (int k = CPU_NB-1; k >= 0; k--) begin
            w_idx = r_rr[j] + DW'(k);
            if (rst_n && !w_full[j] && data_cpu_to_noc_vld[w_idx] && (w_dest[w_idx] == DW'(j))) begin
               w_push[j]     = 1'b1;
               w_grantSrc[j] = w_idx;
            end
         end
         if (w_push[j]) begin
            w_grantRdy[w_grantSrc[j]] = 1'b1;
         end
      end
   end

   assign data_cpu_to_noc_rdy = w_grantRdy;
   assign w_grantCount        = 32'($countones(w_push));

   // Storage is cleared on reset so a discarded word can never resurface at a FIFO head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < CPU_NB; j++) begin
            r_rr[j]    <= '0;
            r_count[j] <= '0;
            r_wrPtr[j] <= '0;
            r_rdPtr[j] <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
               r_mem[j][d] <= '0;
            end
         end
         r_routedCount <= '0;
      end else begin
         for (int j = 0; j < CPU_NB; j++) begin
            if (w_push[j]) begin
               r_mem[j][r_wrPtr[j]] <= data_cpu_to_noc[w_grantSrc[j]*64 +: 64];
               r_wrPtr[j]           <= r_wrPtr[j] + 1'b1;
               r_rr[j]              <= w_grantSrc[j] + 1'b1;
            end
            if (w_pop[j]) begin
               r_rdPtr[j] <= r_rdPtr[j] + 1'b1;
            end
            if (w_push[j] && !w_pop[j]) begin
               r_count[j] <= r_count[j] + 1'b1;
            end else if (!w_push[j] && w_pop[j]) begin
               r_count[j] <= r_count[j] - 1'b1;
            end
         end
         r_routedCount <= r_routedCount + w_grantCount;
      end
   end

   always_comb begin
      data_noc_to_cpu_vld = '0;
      data_noc_to_cpu     = '0;
      for (int j = 0; j < CPU_NB; j++) begin
         data_noc_to_cpu_vld[j]       = (r_count[j] != '0);
         data_noc_to_cpu[j*64 +: 64]  = r_mem[j][r_rdPtr[j]];
      end
   end

   assign routed_count = r_routedCount;

endmodule

// File: tb/tb_noc_router.sv
// Self-checking bench for noc_router: directed scenarios plus randomized traffic,
// all checked against a queue-per-destination reference model.
module tb_noc_router;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int DW    = $clog2(N);

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    vld;
   logic [N-1:0]    rdy;
   logic [N*64-1:0] dIn;
   logic [N-1:0]    nocVld;
   logic [N-1:0]    nocRdy;
   logic [N*64-1:0] dOut;
   logic [31:0]     routed;

   noc_router #(.CPU_NB(N), .FIFO_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .data_cpu_to_noc_vld (vld),
      .data_cpu_to_noc_rdy (rdy),
      .data_cpu_to_noc     (dIn),
      .data_noc_to_cpu_vld (nocVld),
      .data_noc_to_cpu_rdy (nocRdy),
      .data_noc_to_cpu     (dOut),
      .routed_count        (routed)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: one queue per destination, a round-robin pointer per destination,
   // and a running total of accepted words.
   logic [63:0] mq [N][$];
   int          mrr [N];
   logic [31:0] mcnt;
   logic [N-1:0] expRdy;
   int          expSrc [N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] mk_word(int d);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[56 +: DW] = d[DW-1:0];
      return w;
   endfunction

   function automatic int dest_of(int s);
      return int'(dIn[s*64+56 +: DW]);
   endfunction

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         mq[j].delete();
         mrr[j] = 0;
      end
      mcnt = '0;
   endtask

   // The winner for a destination is the requester at the smallest cyclic distance from its pointer.
   task automatic compute_expected();
      expRdy = '0;
      for (int j = 0; j < N; j++) begin
         int best;
         int bestDist;
         best     = -1;
         bestDist = N;
         if (rst_n && mq[j].size() < DEPTH) begin
            for (int s = 0; s < N; s++) begin
               if (vld[s] && dest_of(s) == j && ((s - mrr[j] + N) % N) < bestDist) begin
                  bestDist = (s - mrr[j] + N) % N;
                  best     = s;
               end
            end
         end
         expSrc[j] = best;
         if (best >= 0) expRdy[best] = 1'b1;
      end
   endtask

   task automatic tick();
      compute_expected();
      @(posedge clk);
      if (rst_n) begin
         for (int j = 0; j < N; j++) begin
            if (mq[j].size() != 0 && nocRdy[j]) void'(mq[j].pop_front());
         end
         for (int j = 0; j < N; j++) begin
            if (expSrc[j] >= 0) begin
               mq[j].push_back(dIn[expSrc[j]*64 +: 64]);
               mcnt   = mcnt + 1;
               mrr[j] = (expSrc[j] + 1) % N;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      vld    = '0;
      nocRdy = '0;
      dIn    = '0;
      rst_n  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) dIn[i*64 +: 64] = mk_word(i);
      vld = '1;
      #1;
      testsRun++;
      if (rdy !== '0) begin testsFailed++; $display("[TB] FAIL reset_rdy_forced: got %b expected 0", rdy); end
      testsRun++;
      if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL reset_vld: got %b expected 0", nocVld); end
      testsRun++;
      if (dOut !== '0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 0", dOut); end
      testsRun++;
      if (routed !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d expected 0", routed); end
      rst_n = 1'b1;
      #1;
      testsRun++;
      if (rdy !== {N{1'b1}}) begin testsFailed++; $display("[TB] FAIL rdy_after_release: got %b expected %b", rdy, {N{1'b1}}); end
      vld = '0;
      #1;
   endtask

   task automatic test_single_word();
      dIn[1*64 +: 64] = 64'h02AA_BBCC_DDEE_FF00;
      vld = 4'b0010;
      #1;
      testsRun++;
      if (rdy !== 4'b0010) begin testsFailed++; $display("[TB] FAIL single_rdy: got %b expected 0010", rdy); end
      tick();
      vld = '0;
      testsRun++;
      if (nocVld !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_vld: got %b expected 0100", nocVld); end
      testsRun++;
      if (dOut[2*64 +: 64] !== 64'h02AA_BBCC_DDEE_FF00) begin
         testsFailed++; $display("[TB] FAIL single_data: got %h expected 02aabbccddeeff00", dOut[2*64 +: 64]);
      end
      testsRun++;
      if (routed !== 32'd1) begin testsFailed++; $display("[TB] FAIL single_count: got %0d expected 1", routed); end
      nocRdy[2] = 1'b1;
      tick();
      nocRdy = '0;
      testsRun++;
      if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL single_drain: got %b expected 0", nocVld); end
   endtask

   task automatic test_round_robin();
      logic [63:0] lastWord;
      lastWord = '0;
      for (int i = 0; i < N; i++) dIn[i*64 +: 64] = mk_word(0);
      vld    = '1;
      nocRdy = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         #1;
         testsRun++;
         if (rdy !== (N'(1) << (c % N))) begin
            testsFailed++; $display("[TB] FAIL rr_order cycle %0d: got %b expected %b", c, rdy, N'(1) << (c % N));
         end
         if (c > 0) begin
            testsRun++;
            if (nocVld[0] !== 1'b1 || dOut[63:0] !== lastWord) begin
               testsFailed++; $display("[TB] FAIL rr_head cycle %0d: got vld=%b %h expected vld=1 %h", c, nocVld[0], dOut[63:0], lastWord);
            end
         end
         lastWord = dIn[(c % N)*64 +: 64];
         tick();
         for (int s = 0; s < N; s++) if (expRdy[s]) dIn[s*64 +: 64] = mk_word(0);
      end
      vld = '0;
      tick();
      nocRdy = '0;
      testsRun++;
      if (nocVld[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_drain: got %b expected 0", nocVld[0]); end
   endtask

   task automatic test_full_fifo();
      logic [63:0] words [6];
      int idx;
      int dutAcc;
      idx    = 0;
      dutAcc = 0;
      for (int w = 0; w < 6; w++) words[w] = mk_word(3);
      nocRdy = '0;
      vld    = '0;
      for (int c = 0; c < 8; c++) begin
         dIn[63:0] = words[(idx < 6) ? idx : 5];
         vld[0]    = (idx < 6);
         #1;
         compute_expected();
         testsRun++;
         if (rdy !== expRdy) begin testsFailed++; $display("[TB] FAIL full_rdy cycle %0d: got %b expected %b", c, rdy, expRdy); end
         if (vld[0] && rdy[0]) begin
            idx++;
            dutAcc++;
         end
         tick();
      end
      testsRun++;
      if (dutAcc != 4) begin testsFailed++; $display("[TB] FAIL full_accepted: got %0d expected 4", dutAcc); end
      nocRdy[3] = 1'b1;
      #1;
      testsRun++;
      if (rdy[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_pop_same_cycle: got %b expected 0", rdy[0]); end
      tick();
      nocRdy = '0;
      #1;
      testsRun++;
      if (rdy[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_after_pop: got %b expected 1", rdy[0]); end
      tick();
      vld = '0;
      nocRdy[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         testsRun++;
         if (nocVld[3] !== 1'b1 || dOut[3*64 +: 64] !== words[k+1]) begin
            testsFailed++; $display("[TB] FAIL full_drain %0d: got vld=%b %h expected vld=1 %h", k, nocVld[3], dOut[3*64 +: 64], words[k+1]);
         end
         tick();
      end
      nocRdy = '0;
      testsRun++;
      if (nocVld[3] !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_empty: got %b expected 0", nocVld[3]); end
   endtask

   task automatic test_parallel();
      logic [63:0] pw [N];
      logic [31:0] expCount;
      for (int i = 0; i < N; i++) begin
         pw[i] = mk_word((i + 1) % N);
         dIn[i*64 +: 64] = pw[i];
      end
      vld    = '1;
      nocRdy = '0;
      #1;
      testsRun++;
      if (rdy !== {N{1'b1}}) begin testsFailed++; $display("[TB] FAIL parallel_rdy: got %b expected %b", rdy, {N{1'b1}}); end
      expCount = mcnt + 32'd4;
      tick();
      vld = '0;
      testsRun++;
      if (routed !== expCount) begin testsFailed++; $display("[TB] FAIL parallel_count: got %0d expected %0d", routed, expCount); end
      for (int j = 0; j < N; j++) begin
         testsRun++;
         if (nocVld[j] !== 1'b1 || dOut[j*64 +: 64] !== pw[(j + N - 1) % N]) begin
            testsFailed++; $display("[TB] FAIL parallel_data dest %0d: got vld=%b %h expected vld=1 %h", j, nocVld[j], dOut[j*64 +: 64], pw[(j + N - 1) % N]);
         end
      end
      nocRdy = '1;
      tick();
      nocRdy = '0;
      testsRun++;
      if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL parallel_drain: got %b expected 0", nocVld); end
   endtask

   task automatic test_pointer_wrap();
      logic [63:0] sent [$];
      logic [63:0] got [$];
      int si;
      int cyc;
      si  = 0;
      cyc = 0;
      for (int k = 0; k < 20; k++) sent.push_back(mk_word(1));
      while ((si < 20 || got.size() < 20) && cyc < 300) begin
         vld[0]    = (si < 20);
         dIn[63:0] = sent[(si < 20) ? si : 19];
         nocRdy[1] = 1'($urandom_range(0, 1));
         #1;
         if (nocVld[1] && nocRdy[1]) got.push_back(dOut[1*64 +: 64]);
         if (vld[0] && rdy[0]) si++;
         tick();
         cyc++;
      end
      vld    = '0;
      nocRdy = '0;
      testsRun++;
      if (got.size() != 20) begin testsFailed++; $display("[TB] FAIL wrap_count: got %0d expected 20", got.size()); end
      for (int k = 0; k < 20 && k < got.size(); k++) begin
         testsRun++;
         if (got[k] !== sent[k]) begin testsFailed++; $display("[TB] FAIL wrap_word %0d: got %h expected %h", k, got[k], sent[k]); end
      end
      testsRun++;
      if (nocVld[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL wrap_leftover: got %b expected 0", nocVld[1]); end
   endtask

   task automatic test_random_traffic();
      vld = '0;
      for (int c = 0; c < 300; c++) begin
         for (int s = 0; s < N; s++) begin
            if (!vld[s] && $urandom_range(0, 3) != 0) begin
               vld[s] = 1'b1;
               dIn[s*64 +: 64] = mk_word($urandom_range(0, N-1));
            end
            nocRdy[s] = ($urandom_range(0, 2) == 0);
         end
         #1;
         compute_expected();
         testsRun++;
         if (rdy !== expRdy) begin testsFailed++; $display("[TB] FAIL rand_rdy cycle %0d: got %b expected %b", c, rdy, expRdy); end
         testsRun++;
         if (routed !== mcnt) begin testsFailed++; $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", c, routed, mcnt); end
         for (int j = 0; j < N; j++) begin
            testsRun++;
            if (nocVld[j] !== (mq[j].size() != 0)) begin
               testsFailed++; $display("[TB] FAIL rand_vld cycle %0d dest %0d: got %b expected %b", c, j, nocVld[j], mq[j].size() != 0);
            end
            if (mq[j].size() != 0) begin
               testsRun++;
               if (dOut[j*64 +: 64] !== mq[j][0]) begin
                  testsFailed++; $display("[TB] FAIL rand_data cycle %0d dest %0d: got %h expected %h", c, j, dOut[j*64 +: 64], mq[j][0]);
               end
            end
         end
         tick();
         for (int s = 0; s < N; s++) if (expRdy[s]) vld[s] = 1'b0;
      end
      vld    = '0;
      nocRdy = '1;
      repeat (DEPTH) tick();
      nocRdy = '0;
      testsRun++;
      if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL rand_drain: got %b expected 0", nocVld); end
   endtask

   task automatic test_async_reset();
      logic [63:0] fresh;
      nocRdy = '0;
      vld    = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         dIn[3*64 +: 64] = mk_word(2);
         tick();
      end
      dIn[3*64 +: 64] = mk_word(2);
      testsRun++;
      if (nocVld[2] !== 1'b1) begin testsFailed++; $display("[TB] FAIL areset_prefill: got %b expected 1", nocVld[2]); end
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      testsRun++;
      if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL areset_vld: got %b expected 0", nocVld); end
      testsRun++;
      if (routed !== 32'd0) begin testsFailed++; $display("[TB] FAIL areset_count: got %0d expected 0", routed); end
      testsRun++;
      if (dOut !== '0) begin testsFailed++; $display("[TB] FAIL areset_data: got %h expected 0", dOut); end
      testsRun++;
      if (rdy !== '0) begin testsFailed++; $display("[TB] FAIL areset_rdy: got %b expected 0", rdy); end
      @(posedge clk);
      #1;
      testsRun++;
      if (rdy !== '0 || nocVld !== '0) begin
         testsFailed++; $display("[TB] FAIL areset_hold: got rdy=%b vld=%b expected 0 0", rdy, nocVld);
      end
      #3;
      rst_n  = 1'b1;
      vld    = '0;
      nocRdy = '1;
      for (int k = 0; k < 4; k++) begin
         tick();
         testsRun++;
         if (nocVld !== '0) begin testsFailed++; $display("[TB] FAIL areset_ghost %0d: got %b expected 0", k, nocVld); end
      end
      nocRdy = '0;
      fresh = mk_word(2);
      dIn[63:0] = fresh;
      vld = 4'b0001;
      tick();
      vld = '0;
      testsRun++;
      if (nocVld[2] !== 1'b1 || dOut[2*64 +: 64] !== fresh) begin
         testsFailed++; $display("[TB] FAIL areset_fresh: got vld=%b %h expected vld=1 %h", nocVld[2], dOut[2*64 +: 64], fresh);
      end
      testsRun++;
      if (routed !== 32'd1) begin testsFailed++; $display("[TB] FAIL areset_recount: got %0d expected 1", routed); end
   endtask

   initial begin
      rst_n  = 1'b0;
      vld    = '0;
      nocRdy = '0;
      dIn    = '0;
      test_reset();
      test_single_word();
      test_round_robin();
      test_full_fifo();
      test_parallel();
      test_pointer_wrap();
      test_random_traffic();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
